// File: rtl/sd_cmd_layer_if.sv
// Host-controller side of the SD command layer: command request, busy/done
// handshake and decoded response status.
interface sd_cmd_layer_if;
    logic         i_cmd_stb;
    logic [5:0]   i_cmd_index;
    logic [31:0]  i_cmd_arg;
    logic [1:0]   i_rsp_type;
    logic         i_rsp_crc_chk;
    logic         o_busy;
    logic         o_done;
    logic [5:0]   o_rsp_index;
    logic [127:0] o_rsp;
    logic         o_crc_err;
    logic         o_end_err;
    logic         o_timeout;

    modport master (
        output i_cmd_stb, i_cmd_index, i_cmd_arg, i_rsp_type, i_rsp_crc_chk,
        input  o_busy, o_done, o_rsp_index, o_rsp, o_crc_err, o_end_err, o_timeout
    );

    modport slave (
        input  i_cmd_stb, i_cmd_index, i_cmd_arg, i_rsp_type, i_rsp_crc_chk,
        output o_busy, o_done, o_rsp_index, o_rsp, o_crc_err, o_end_err, o_timeout
    );
endinterface

// File: rtl/sd_cmd_layer.sv
// SD CMD-line serializer/deserializer: sends a 48-bit command frame with CRC7,
// then hunts for and captures a 48- or 136-bit response and checks it.
module sd_cmd_layer #(
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned NCC_CYCLES   = 8,
    parameter int unsigned TURNAROUND   = 2
) (
    input  logic           clk,
    input  logic           rst,
    sd_cmd_layer_if.slave  io_host,
    output logic           o_sd_cmd_dir,
    output logic           o_sd_cmd_out,
    input  logic           i_sd_cmd_in
);

    typedef enum logic [2:0] {StIdle, StTx, StRspWait, StRspRx, StNcc} state_e;

    localparam logic [7:0] LP_TX_LAST     = 8'd47;
    localparam logic [7:0] LP_SHORT_START = 8'd46;
    localparam logic [7:0] LP_LONG_START  = 8'd134;
    localparam logic [7:0] LP_CRC_LO      = 8'd8;
    localparam logic [7:0] LP_CRC_HI      = 8'd127;
    localparam logic [7:0] LP_TURN        = 8'(TURNAROUND);
    localparam logic [7:0] LP_TMO_LAST    = 8'(RESP_TIMEOUT - 1);
    localparam logic [7:0] LP_NCC_LAST    = 8'(NCC_CYCLES - 1);

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_e         r_state;
    state_e         w_state_next;
    logic   [7:0]   r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_dir;
    logic           r_out;
    logic   [46:0]  r_tx_sh;
    logic   [1:0]   r_rsp_type;
    logic           r_crc_chk;
    logic   [6:0]   r_crc;
    logic   [126:0] r_rx_sh;
    logic   [5:0]   r_rsp_index;
    logic   [127:0] r_rsp;
    logic           r_crc_err;
    logic           r_end_err;
    logic           r_timeout;

    logic   [39:0]  w_tx_hdr;
    logic   [6:0]   w_tx_crc;
    logic   [47:0]  w_frame;
    logic   [127:0] w_word;
    logic           w_long;
    logic           w_has_rsp;
    logic           w_accept;
    logic           w_tx_last;
    logic           w_rsp_start;
    logic           w_rsp_tmo;
    logic           w_rx_last;
    logic           w_ncc_last;

    assign w_tx_hdr  = {2'b01, io_host.i_cmd_index, io_host.i_cmd_arg};
    assign w_frame   = {w_tx_hdr, w_tx_crc, 1'b1};
    assign w_word    = {r_rx_sh, i_sd_cmd_in};
    assign w_long    = (r_rsp_type == 2'd2);
    assign w_has_rsp = (r_rsp_type == 2'd1) || (r_rsp_type == 2'd2);

    always_comb begin
        w_tx_crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            w_tx_crc = crc7_step(w_tx_crc, w_tx_hdr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_tx_last    = 1'b0;
        w_rsp_start  = 1'b0;
        w_rsp_tmo    = 1'b0;
        w_rx_last    = 1'b0;
        w_ncc_last   = 1'b0;
        case (r_state)
            StIdle: begin
                if (io_host.i_cmd_stb && !r_busy) begin
                    w_accept     = 1'b1;
                    w_state_next = StTx;
                end
            end
            StTx: begin
                if (r_cnt == LP_TX_LAST) begin
                    w_tx_last    = 1'b1;
                    w_state_next = w_has_rsp ? StRspWait : StNcc;
                end
            end
            StRspWait: begin
                // r_cnt numbers the released-line clocks, starting at 1
                if ((r_cnt > LP_TURN) && !i_sd_cmd_in) begin
                    w_rsp_start  = 1'b1;
                    w_state_next = StRspRx;
                end else if (r_cnt == LP_TMO_LAST) begin
                    w_rsp_tmo    = 1'b1;
                    w_state_next = StNcc;
                end
            end
            StRspRx: begin
                if (r_cnt == 8'd0) begin
                    w_rx_last    = 1'b1;
                    w_state_next = StNcc;
                end
            end
            StNcc: begin
                if (r_cnt == LP_NCC_LAST) begin
                    w_ncc_last   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dir       <= 1'b0;
            r_out       <= 1'b1;
            r_tx_sh     <= '0;
            r_rsp_type  <= 2'd0;
            r_crc_chk   <= 1'b0;
            r_crc       <= 7'h00;
            r_rx_sh     <= '0;
            r_rsp_index <= 6'd0;
            r_rsp       <= '0;
            r_crc_err   <= 1'b0;
            r_end_err   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_busy     <= 1'b1;
                        r_dir      <= 1'b1;
                        r_out      <= w_frame[47];
                        r_tx_sh    <= w_frame[46:0];
                        r_cnt      <= 8'd0;
                        r_rsp_type <= io_host.i_rsp_type;
                        r_crc_chk  <= io_host.i_rsp_crc_chk;
                        r_crc_err  <= 1'b0;
                        r_end_err  <= 1'b0;
                        r_timeout  <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                StTx: begin
                    if (w_tx_last) begin
                        r_dir <= 1'b0;
                        r_out <= 1'b1;
                        r_cnt <= w_has_rsp ? 8'd1 : 8'd0;
                    end else begin
                        r_out   <= r_tx_sh[46];
                        r_tx_sh <= {r_tx_sh[45:0], 1'b1};
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                StRspWait: begin
                    if (w_rsp_start) begin
                        // r_cnt now tracks the frame position of the next bit
                        r_cnt <= w_long ? LP_LONG_START : LP_SHORT_START;
                        r_crc <= 7'h00;
                    end else if (w_rsp_tmo) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StRspRx: begin
                    r_rx_sh <= {r_rx_sh[125:0], i_sd_cmd_in};
                    if ((r_cnt >= LP_CRC_LO) && (r_cnt <= LP_CRC_HI)) begin
                        r_crc <= crc7_step(r_crc, i_sd_cmd_in);
                    end
                    if (w_rx_last) begin
                        r_end_err <= !i_sd_cmd_in;
                        r_crc_err <= r_crc_chk && (r_crc != r_rx_sh[6:0]);
                        if (w_long) begin
                            r_rsp_index <= 6'h3F;
                            r_rsp       <= w_word;
                        end else begin
                            r_rsp_index <= w_word[45:40];
                            r_rsp       <= {96'd0, w_word[39:8]};
                        end
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                StNcc: begin
                    if (w_ncc_last) begin
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sd_cmd_dir        = r_dir;
    assign o_sd_cmd_out        = r_out;
    assign io_host.o_busy      = r_busy;
    assign io_host.o_done      = r_done;
    assign io_host.o_rsp_index = r_rsp_index;
    assign io_host.o_rsp       = r_rsp;
    assign io_host.o_crc_err   = r_crc_err;
    assign io_host.o_end_err   = r_end_err;
    assign io_host.o_timeout   = r_timeout;

endmodule
